// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - instruction fetch FSM with a circular fetch buffer
module fetch_unit #(
   parameter int          DEPTH    = 4,
   parameter logic [31:0] RESET_PC = 32'h00000060
) (
   input  logic        clk,
   input  logic        reset_n,
   output logic        instr_read,
   output logic [31:0] instr_mem_address,
   input  logic        instr_mem_resp,
   input  logic [31:0] instr_mem_rdata,
   input  logic        redirect,
   input  logic [31:0] redirect_pc,
   input  logic        iq_ready,
   output logic        fetch_valid,
   output logic [31:0] fetch_instr,
   output logic [31:0] fetch_pc
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   typedef enum logic [1:0] {IDLE, REQ, DISCARD} state_t;

   state_t          state;
   logic [31:0]     next_pc;
   logic [31:0]     req_addr;
   logic [PW-1:0]   head;
   logic [PW-1:0]   tail;
   logic [CW-1:0]   count;
   logic [CW-1:0]   count_after;
   logic [31:0]     buf_pc    [DEPTH];
   logic [31:0]     buf_instr [DEPTH];
   logic            push;
   logic            pop;
   logic            room;

   // A redirect flushes the buffer, so it suppresses both push and pop that cycle.
   always_comb begin
      pop         = fetch_valid && iq_ready && !redirect;
      push        = (state == REQ) && instr_mem_resp && !redirect;
      count_after = count + CW'(push) - CW'(pop);
      room        = count_after < CW'(DEPTH);
   end

   assign instr_mem_address = req_addr;
   assign fetch_valid       = (count != '0);
   assign fetch_instr       = fetch_valid ? buf_instr[head] : 32'h0;
   assign fetch_pc          = fetch_valid ? buf_pc[head]    : 32'h0;

   // Buffer storage; contents are only observed through the valid-gated head outputs.
   always_ff @(posedge clk) begin
      if (push) begin
         buf_pc[tail]    <= req_addr;
         buf_instr[tail] <= instr_mem_rdata;
      end
   end

   // Head/tail pointers and occupancy; pointers wrap naturally at DEPTH.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         head  <= '0;
         tail  <= '0;
         count <= '0;
      end else if (redirect) begin
         head  <= '0;
         tail  <= '0;
         count <= '0;
      end else begin
         if (push) tail <= tail + 1'b1;
         if (pop)  head <= head + 1'b1;
         count <= count_after;
      end
   end

   // Request FSM; at most one request is outstanding and its address stays put until answered.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state      <= IDLE;
         next_pc    <= RESET_PC;
         req_addr   <= RESET_PC;
         instr_read <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (redirect) begin
                  next_pc    <= redirect_pc;
                  req_addr   <= redirect_pc;
                  state      <= REQ;
                  instr_read <= 1'b1;
               end else if (room) begin
                  req_addr   <= next_pc;
                  state      <= REQ;
                  instr_read <= 1'b1;
               end
            end
            REQ: begin
               if (instr_mem_resp) begin
                  if (redirect) begin
                     // data for the stale path is dropped, restart at the target
                     next_pc  <= redirect_pc;
                     req_addr <= redirect_pc;
                  end else begin
                     next_pc <= req_addr + 32'd4;
                     if (room) begin
                        req_addr <= req_addr + 32'd4;
                     end else begin
                        state      <= IDLE;
                        instr_read <= 1'b0;
                     end
                  end
               end else if (redirect) begin
                  // the old request is still in flight; wait for it and throw it away
                  next_pc <= redirect_pc;
                  state   <= DISCARD;
               end
            end
            DISCARD: begin
               if (redirect) next_pc <= redirect_pc;
               if (instr_mem_resp) begin
                  req_addr <= redirect ? redirect_pc : next_pc;
                  state    <= REQ;
               end
            end
            default: begin
               state      <= IDLE;
               instr_read <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - randomized model-checked bench for fetch_unit
module tb_fetch_unit;

   localparam int DEPTH = 4;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        instr_read;
   logic [31:0] instr_mem_address;
   logic        instr_mem_resp;
   logic [31:0] instr_mem_rdata;
   logic        redirect;
   logic [31:0] redirect_pc;
   logic        iq_ready;
   logic        fetch_valid;
   logic [31:0] fetch_instr;
   logic [31:0] fetch_pc;

   fetch_unit #(.DEPTH(DEPTH), .RESET_PC(32'h00000060)) dut (
      .clk               (clk),
      .reset_n           (reset_n),
      .instr_read        (instr_read),
      .instr_mem_address (instr_mem_address),
      .instr_mem_resp    (instr_mem_resp),
      .instr_mem_rdata   (instr_mem_rdata),
      .redirect          (redirect),
      .redirect_pc       (redirect_pc),
      .iq_ready          (iq_ready),
      .fetch_valid       (fetch_valid),
      .fetch_instr       (fetch_instr),
      .fetch_pc          (fetch_pc)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] instr;
   } entry_t;

   entry_t      q[$];
   logic [31:0] exp_pc;
   logic        discard;
   logic [31:0] disc_addr;
   int          pushes;
   int          n_tests;
   int          n_fail;
   logic [31:0] seed_words [3];

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic model_reset();
      q.delete();
      exp_pc  = 32'h00000060;
      discard = 1'b0;
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_instr_read"},  {31'h0, instr_read},  32'h0);
      check({tag, "_fetch_valid"}, {31'h0, fetch_valid}, 32'h0);
      check({tag, "_fetch_instr"}, fetch_instr,          32'h0);
      check({tag, "_fetch_pc"},    fetch_pc,             32'h0);
   endtask

   // One cycle: compare against the model, drive random inputs, advance the model.
   task automatic step(input int resp_pct, input int iq_pct, input int redir_pct);
      logic        r_redir;
      logic        r_resp;
      logic        r_iq;
      logic [31:0] r_pc;
      logic [31:0] r_data;
      logic        do_pop;
      @(negedge clk);
      check("fetch_valid", {31'h0, fetch_valid}, {31'h0, q.size() != 0});
      if (q.size() != 0) begin
         check("fetch_pc",    fetch_pc,    q[0].pc);
         check("fetch_instr", fetch_instr, q[0].instr);
      end
      if (instr_read)
         check("req_addr", instr_mem_address, discard ? disc_addr : exp_pc);
      else
         check("idle_only_when_full", 32'(q.size()), 32'(DEPTH));

      r_redir = ($urandom_range(99) < redir_pct);
      r_pc    = ($urandom_range(9) == 0) ? 32'hFFFF_FFF8 : {$urandom_range(32'h3FFF_FFFF), 2'b00};
      r_iq    = ($urandom_range(99) < iq_pct);
      r_resp  = instr_read ? ($urandom_range(99) < resp_pct) : ($urandom_range(99) < 5);
      r_data  = (pushes < 3) ? seed_words[pushes] : $urandom;
      redirect        = r_redir;
      redirect_pc     = r_pc;
      iq_ready        = r_iq;
      instr_mem_resp  = r_resp;
      instr_mem_rdata = r_data;

      do_pop = (q.size() != 0) && r_iq && !r_redir;
      if (r_redir) begin
         q.delete();
         exp_pc = r_pc;
         if (instr_read && !r_resp) begin
            if (!discard) disc_addr = instr_mem_address;
            discard = 1'b1;
         end else if (instr_read && r_resp) begin
            discard = 1'b0;
         end
      end else begin
         if (do_pop) void'(q.pop_front());
         if (instr_read && r_resp) begin
            if (discard) begin
               discard = 1'b0;
            end else begin
               q.push_back('{pc: exp_pc, instr: r_data});
               exp_pc = exp_pc + 32'd4;
               pushes++;
            end
         end
      end
      check("no_overflow", {31'h0, q.size() <= DEPTH}, 32'h1);
   endtask

   task automatic run_phase(input int cycles, input int resp_pct, input int iq_pct, input int redir_pct);
      for (int i = 0; i < cycles; i++) step(resp_pct, iq_pct, redir_pct);
   endtask

   // Pulses reset low asynchronously, with stray responses while held.
   task automatic pulse_reset();
      @(negedge clk);
      #2 reset_n = 1'b0;
      #1 check_reset_outputs("async_reset");
      for (int i = 0; i < 3; i++) begin
         instr_mem_resp  = 1'b1;
         instr_mem_rdata = $urandom;
         redirect        = 1'b0;
         iq_ready        = 1'b1;
         @(negedge clk);
         check_reset_outputs("in_reset");
      end
      instr_mem_resp = 1'b0;
      reset_n        = 1'b1;
      model_reset();
      @(negedge clk);
      check("first_read",      {31'h0, instr_read}, 32'h1);
      check("first_read_addr", instr_mem_address,   32'h00000060);
   endtask

   initial begin
      seed_words[0]   = 32'h000170b3;
      seed_words[1]   = 32'h0001f133;
      seed_words[2]   = 32'h000271b3;
      n_tests         = 0;
      n_fail          = 0;
      pushes          = 0;
      reset_n         = 1'b0;
      instr_mem_resp  = 1'b0;
      instr_mem_rdata = 32'h0;
      redirect        = 1'b0;
      redirect_pc     = 32'h0;
      iq_ready        = 1'b0;
      model_reset();
      repeat (3) @(negedge clk);
      check_reset_outputs("reset");
      reset_n = 1'b1;
      run_phase(12, 100, 100, 0);
      run_phase(20, 100, 0, 0);
      run_phase(40, 100, 50, 0);
      run_phase(200, 60, 60, 8);
      pulse_reset();
      run_phase(200, 50, 30, 15);
      run_phase(100, 100, 90, 3);
      pulse_reset();
      run_phase(300, 70, 50, 10);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter DEPTH, default 4, SHALL set the fetch buffer entry count (power of two, at least 2).
REQ-002 Parameter RESET_PC, default 32'h00000060, SHALL set the first fetch address after reset.
REQ-003 clk  in  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 reset_n  in  1  SHALL be the reset: asynchronous, active-low.
REQ-005 instr_read  out  1  SHALL be the instruction memory read request.
REQ-006 instr_mem_address  out  32  SHALL be the request address; word aligned.
REQ-007 instr_mem_resp  in  1  SHALL be the single-cycle memory response strobe.
REQ-008 instr_mem_rdata  in  32  SHALL be the instruction word, valid with instr_mem_resp.
REQ-009 redirect  in  1  SHALL be the branch/jump redirect strobe (ROB ld_br).
REQ-010 redirect_pc  in  32  SHALL be the redirect target, valid with redirect.
REQ-011 iq_ready  in  1  SHALL indicate the instruction register / queue accepts an entry this cycle.
REQ-012 fetch_valid  out  1  SHALL indicate that the buffer head holds a valid entry.
REQ-013 fetch_instr  out  32  SHALL be the buffer head instruction.
REQ-014 fetch_pc  out  32  SHALL be the buffer head PC.

Function
REQ-015 The FSM SHALL have states IDLE, REQ, DISCARD; instr_read SHALL be 1 in REQ and DISCARD only.
REQ-016 IDLE -> REQ SHALL occur when occupancy < DEPTH and redirect = 0; req_addr SHALL latch next_pc.
REQ-017 instr_mem_address SHALL equal req_addr and SHALL stay stable while instr_read = 1.
REQ-018 In REQ, on instr_mem_resp with redirect = 0: push {req_addr, instr_mem_rdata}; next_pc = req_addr + 4 (mod 2^32).
REQ-019 After a push, the FSM SHALL stay in REQ with req_addr = new next_pc if post-update occupancy < DEPTH; otherwise it SHALL go to IDLE.
REQ-020 Pop SHALL occur when fetch_valid && iq_ready; the head SHALL advance on the same edge.
REQ-021 A simultaneous push and pop SHALL leave occupancy unchanged; a pop from a full buffer frees one slot in the same cycle.
REQ-022 A push SHALL be visible on fetch_valid/fetch_instr/fetch_pc in the cycle after the resp edge (1-cycle latency).
REQ-023 Pointers SHALL wrap modulo DEPTH; occupancy SHALL be tracked to distinguish full from empty.
REQ-024 Redirect in any state SHALL flush the buffer: occupancy 0, fetch_valid 0 on the next cycle, and no pop that cycle.
REQ-025 Redirect in any state SHALL set next_pc = redirect_pc.
REQ-026 Redirect in REQ without resp SHALL go to DISCARD and keep the old req_addr with instr_read held at 1.
REQ-027 In DISCARD, the response SHALL be dropped and the FSM SHALL then go to REQ with req_addr = next_pc.
REQ-028 Redirect in REQ with resp in the same cycle SHALL drop the data and go to REQ with req_addr = redirect_pc.
REQ-029 Redirect in IDLE SHALL go to REQ with req_addr = redirect_pc.
REQ-030 A redirect during DISCARD SHALL update next_pc only; the latest target wins.
REQ-031 At most one request SHALL be outstanding; a resp in IDLE SHALL be ignored.

Reset
REQ-032 While reset_n = 0: state IDLE, next_pc = req_addr = RESET_PC, occupancy 0, pointers 0.
REQ-033 While reset_n = 0: instr_read 0, fetch_valid 0, fetch_instr 0, fetch_pc 0.
REQ-034 Reset asserted mid-request SHALL abandon the request; a resp arriving during or after reset while in IDLE SHALL be ignored.
REQ-035 The first instr_read SHALL assert in the first cycle after reset_n rises, at address RESET_PC.

Verification
REQ-036 Reset release, iq_ready = 1, memory responds one cycle after each request with 32'h000170b3, 32'h0001f133, 32'h000271b3 -> entries at PCs 0x60, 0x64, 0x68, in order, each 1 cycle after resp.
REQ-037 iq_ready = 0, continuous responses -> exactly 4 pushes (PCs 0x60..0x6c), then IDLE with instr_read = 0; one pop -> request to 0x70 issues next cycle.
REQ-038 Redirect to 0x200 while a request to 0x64 is pending -> instr_read stays high at 0x64, that resp is dropped, the next request is 0x200, and the first entry has fetch_pc 0x200.
REQ-039 Redirect to 0x300 in the same cycle as resp for 0x68, buffer holding 2 entries -> fetch_valid 0 next cycle, no 0x68 entry, next request 0x300.
REQ-040 Full buffer with simultaneous pop and resp -> occupancy stays 4 and order is preserved across pointer wrap.
REQ-041 reset_n pulsed low mid-request, then released -> all outputs 0 during reset, and the first request after release is to 0x60.
